xlgmii_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing the 128-bit XLGMII TX bridge between NUM_PORTS AXI4-Stream

---
 rtl/xlgmii_tx_arb_pkg.sv | 18 +
 rtl/xlgmii_tx_rr_picker.sv | 27 ++
 rtl/xlgmii_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_xlgmii_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlgmii_tx_arb_pkg.sv
// Shared types and constants for the XLGMII TX frame arbiter.
package xlgmii_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] ABORT_KEEP = 16'h0001;
  localparam logic [7:0]  STALL_SAT  = 8'd255;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xlgmii_tx_rr_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module xlgmii_tx_rr_picker
  import xlgmii_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int GRANT_W   = grant_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GRANT_W-1:0]   ptr,
  output logic [GRANT_W-1:0]   pick,
  output logic                 any
);

  int idx_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx_s = 0;
    pick  = '0;
    any   = |req;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx_s = (int'(ptr) + off) % NUM_PORTS;
      pick  = req[idx_s] ? idx_s[GRANT_W-1:0] : pick;
    end
  end

endmodule

// File: rtl/xlgmii_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the XLGMII TX bridge, with
// mid-frame underrun detection and stall-driven frame abort.
module xlgmii_tx_arbiter
  import xlgmii_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int KEEP_WIDTH  = 16,
  parameter int STALL_LIMIT = 16,
  localparam int GRANT_W    = grant_width(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata  [NUM_PORTS],
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep  [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  s_axis_tvalid,
  output logic [NUM_PORTS-1:0]  s_axis_tready,
  input  logic [NUM_PORTS-1:0]  s_axis_tlast,
  input  logic [NUM_PORTS-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  grant_valid,
  output logic [GRANT_W-1:0]    grant_id,
  output logic                  error_underrun,
  output logic                  error_abort
);

  if (DATA_WIDTH != 128 || KEEP_WIDTH != DATA_WIDTH / 8 || NUM_PORTS < 2 || NUM_PORTS > 16 ||
      STALL_LIMIT < 1 || STALL_LIMIT > 255) begin : g_bad_params
    $error("xlgmii_tx_arbiter: unsupported parameter set");
  end

  localparam logic [7:0] STALL_LIMIT_C = 8'(STALL_LIMIT);

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [7:0]           stall_cnt_q, stall_cnt_d;
  logic                 err_underrun_q, err_underrun_d;
  logic                 err_abort_q, err_abort_d;
  logic [GRANT_W-1:0]   pick_s;
  logic                 pick_any_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic [7:0]           stall_inc_s;

  xlgmii_tx_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .GRANT_W   (GRANT_W)
  ) u_picker (
    .req  (s_axis_tvalid),
    .ptr  (rr_ptr_q),
    .pick (pick_s),
    .any  (pick_any_s)
  );

  assign sel_valid_s    = s_axis_tvalid[grant_id_q];
  assign sel_last_s     = s_axis_tlast[grant_id_q];
  assign stall_inc_s    = (stall_cnt_q == STALL_SAT) ? stall_cnt_q : stall_cnt_q + 8'd1;
  assign grant_valid    = grant_valid_q;
  assign grant_id       = grant_id_q;
  assign error_underrun = err_underrun_q;
  assign error_abort    = err_abort_q;

  // Next-state, datapath mux and handshake steering.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    grant_valid_d  = grant_valid_q;
    stall_cnt_d    = stall_cnt_q;
    err_underrun_d = 1'b0;
    err_abort_d    = 1'b0;
    s_axis_tready  = '0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_cnt_d = 8'd0;
        if (pick_any_s) begin
          grant_id_d    = pick_s;
          rr_ptr_d      = pick_s;
          grant_valid_d = 1'b1;
          state_d       = PASS;
        end else begin
          grant_valid_d = 1'b0;
        end
      end
      PASS: begin
        m_axis_tdata  = s_axis_tdata[grant_id_q];
        m_axis_tkeep  = s_axis_tkeep[grant_id_q];
        m_axis_tvalid = sel_valid_s;
        m_axis_tlast  = sel_last_s;
        m_axis_tuser  = s_axis_tuser[grant_id_q];
        s_axis_tready[grant_id_q] = m_axis_tready;
        if (m_axis_tready && sel_valid_s) begin
          stall_cnt_d = 8'd0;
          if (sel_last_s) begin
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end else begin
            state_d = PASS;
          end
        end else if (m_axis_tready) begin
          // Bridge wants data but the source has none: XLGMII cannot idle mid-frame.
          err_underrun_d = 1'b1;
          stall_cnt_d    = stall_inc_s;
          if (stall_inc_s >= STALL_LIMIT_C) begin
            state_d = ABORT;
          end else begin
            state_d = PASS;
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tkeep  = ABORT_KEEP;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          err_abort_d = 1'b1;
          stall_cnt_d = 8'd0;
          state_d     = DRAIN;
        end else begin
          state_d = ABORT;
        end
      end
      DRAIN: begin
        s_axis_tready[grant_id_q] = 1'b1;
        if (sel_valid_s && sel_last_s) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  // State, grant, stall counter and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      rr_ptr_q       <= GRANT_W'(NUM_PORTS - 1);
      grant_valid_q  <= 1'b0;
      stall_cnt_q    <= 8'd0;
      err_underrun_q <= 1'b0;
      err_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_valid_q  <= grant_valid_d;
      stall_cnt_q    <= stall_cnt_d;
      err_underrun_q <= err_underrun_d;
      err_abort_q    <= err_abort_d;
    end
  end

endmodule

// File: tb/tb_xlgmii_tx_arbiter.sv
// Directed bench for xlgmii_tx_arbiter: vector table plus hand-written corner sequences.
module tb_xlgmii_tx_arbiter;

  logic         clk;
  logic         rst;
  logic [127:0] s_tdata [4];
  logic [15:0]  s_tkeep [4];
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tuser;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         m_tuser;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         error_underrun;
  logic         error_abort;

  xlgmii_tx_arbiter #(
    .NUM_PORTS   (4),
    .DATA_WIDTH  (128),
    .KEEP_WIDTH  (16),
    .STALL_LIMIT (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .error_underrun (error_underrun),
    .error_abort    (error_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mrdy;
    logic       mv;
    logic       ml;
    logic [7:0] md;
    logic [3:0] rdy;
    logic       gv;
    logic [1:0] gid;
  } vec_t;

  typedef struct packed {
    logic [7:0]  d;
    logic        last;
    logic [15:0] keep;
    logic        user;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // source models: beat counters per port, optional mid-frame gap
  int frames_left [4];
  int flen        [4];
  int beat        [4];
  int gap_at      [4];
  int gap_len     [4];
  int gap_spent   [4];
  logic [3:0] fire;

  beat_t beats [$];
  int    gids  [$];
  int    n_under;
  int    n_abort;
  logic  prev_gv;

  vec_t  tv [27];
  beat_t exp_b [$];
  int    exp_g [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mrdy, input logic mv, input logic ml, input logic [7:0] md,
                              input logic [3:0] rdy, input logic gv, input logic [1:0] gid);
    vec_t v;
    v.mrdy = mrdy; v.mv = mv; v.ml = ml; v.md = md; v.rdy = rdy; v.gv = gv; v.gid = gid;
    return v;
  endfunction

  function automatic beat_t mkb(input logic [7:0] d, input logic l, input logic [15:0] k, input logic u);
    beat_t b;
    b.d = d; b.last = l; b.keep = k; b.user = u;
    return b;
  endfunction

  function automatic logic in_gap(input int p);
    return frames_left[p] > 0 && beat[p] == gap_at[p] && gap_spent[p] < gap_len[p];
  endfunction

  task automatic drive_src();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p] = (frames_left[p] > 0) && !in_gap(p);
      s_tlast[p]  = (beat[p] == flen[p] - 1);
      s_tdata[p]  = 128'(p * 16 + beat[p]);
      s_tkeep[p]  = 16'hffff;
      s_tuser[p]  = 1'b0;
    end
  endtask

  task automatic cfg(input int p, input int frames, input int len, input int gat, input int glen);
    frames_left[p] = frames; flen[p] = len; beat[p] = 0;
    gap_at[p] = gat; gap_len[p] = glen; gap_spent[p] = 0;
    drive_src();
  endtask

  task automatic pre(input logic mrdy);
    m_tready = mrdy;
    @(negedge clk);
  endtask

  task automatic post();
    fire = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (in_gap(p)) begin
        gap_spent[p]++;
      end else if (fire[p]) begin
        if (beat[p] == flen[p] - 1) begin
          frames_left[p]--; beat[p] = 0; gap_spent[p] = 0;
        end else begin
          beat[p]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic mon();
    if (grant_valid && !prev_gv) gids.push_back(int'(grant_id));
    prev_gv = grant_valid;
    if (error_underrun) n_under++;
    if (error_abort) n_abort++;
    if (m_tvalid && m_tready) beats.push_back(mkb(m_tdata[7:0], m_tlast, m_tkeep, m_tuser));
  endtask

  task automatic clear_mon();
    beats.delete(); gids.delete(); exp_b.delete(); exp_g.delete();
    n_under = 0; n_abort = 0; prev_gv = 1'b0;
  endtask

  task automatic collect(input int n, input logic mrdy);
    for (int i = 0; i < n; i++) begin
      pre(mrdy);
      mon();
      post();
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, " beat count"}, beats.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < beats.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), 32'(beats[i]), 32'(exp_b[i]));
    chk({tag, " grant count"}, gids.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < gids.size(); i++)
      chk($sformatf("%s grant%0d", tag, i), gids[i], exp_g[i]);
  endtask

  task automatic apply_vec(input int i);
    pre(tv[i].mrdy);
    chk($sformatf("v%0d m_tvalid", i), m_tvalid, tv[i].mv);
    if (tv[i].mv) begin
      chk($sformatf("v%0d m_tdata", i), m_tdata[7:0], tv[i].md);
      chk($sformatf("v%0d m_tlast", i), m_tlast, tv[i].ml);
    end
    chk($sformatf("v%0d s_tready", i), s_tready, tv[i].rdy);
    chk($sformatf("v%0d grant_valid", i), grant_valid, tv[i].gv);
    chk($sformatf("v%0d grant_id", i), grant_id, tv[i].gid);
    post();
  endtask

  initial begin
    // test 1: ports 0 and 2, 3-beat frames, one backpressure cycle
    tv[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tv[1]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 2'd0);
    tv[2]  = mk(1'b0, 1'b1, 1'b0, 8'h01, 4'b0000, 1'b1, 2'd0);
    tv[3]  = mk(1'b1, 1'b1, 1'b0, 8'h01, 4'b0001, 1'b1, 2'd0);
    tv[4]  = mk(1'b1, 1'b1, 1'b1, 8'h02, 4'b0001, 1'b1, 2'd0);
    tv[5]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tv[6]  = mk(1'b1, 1'b1, 1'b0, 8'h20, 4'b0100, 1'b1, 2'd2);
    tv[7]  = mk(1'b1, 1'b1, 1'b0, 8'h21, 4'b0100, 1'b1, 2'd2);
    tv[8]  = mk(1'b1, 1'b1, 1'b1, 8'h22, 4'b0100, 1'b1, 2'd2);
    tv[9]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
    // test 2 (after reset): all ports, two 1-beat frames each
    tv[10] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tv[11] = mk(1'b1, 1'b1, 1'b1, 8'h00, 4'b0001, 1'b1, 2'd0);
    tv[12] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tv[13] = mk(1'b1, 1'b1, 1'b1, 8'h10, 4'b0010, 1'b1, 2'd1);
    tv[14] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
    tv[15] = mk(1'b1, 1'b1, 1'b1, 8'h20, 4'b0100, 1'b1, 2'd2);
    tv[16] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
    tv[17] = mk(1'b1, 1'b1, 1'b1, 8'h30, 4'b1000, 1'b1, 2'd3);
    tv[18] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);
    tv[19] = mk(1'b1, 1'b1, 1'b1, 8'h00, 4'b0001, 1'b1, 2'd0);
    tv[20] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    tv[21] = mk(1'b1, 1'b1, 1'b1, 8'h10, 4'b0010, 1'b1, 2'd1);
    tv[22] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);
    tv[23] = mk(1'b1, 1'b1, 1'b1, 8'h20, 4'b0100, 1'b1, 2'd2);
    tv[24] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
    tv[25] = mk(1'b1, 1'b1, 1'b1, 8'h30, 4'b1000, 1'b1, 2'd3);
    tv[26] = mk(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3);

    rst = 1'b1;
    m_tready = 1'b0;
    for (int p = 0; p < 4; p++) cfg(p, 0, 1, 0, 0);
    clear_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset m_tvalid", m_tvalid, 1'b0);
    chk("reset grant_valid", grant_valid, 1'b0);
    chk("reset grant_id", grant_id, 2'd0);
    chk("reset s_tready", s_tready, 4'b0000);
    chk("reset error_underrun", error_underrun, 1'b0);
    chk("reset error_abort", error_abort, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cfg(0, 1, 3, 0, 0);
    cfg(2, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) apply_vec(i);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int p = 0; p < 4; p++) cfg(p, 2, 1, 0, 0);
    for (int i = 10; i < 27; i++) apply_vec(i);

    // test 3: port 1 gaps for 3 cycles mid-frame
    clear_mon();
    cfg(1, 1, 4, 2, 3);
    collect(14, 1'b1);
    for (int i = 0; i < 4; i++) exp_b.push_back(mkb(8'(8'h10 + i), i == 3, 16'hffff, 1'b0));
    exp_g.push_back(1);
    check_stream("short gap");
    chk("short gap underruns", n_under, 3);
    chk("short gap aborts", n_abort, 0);

    // test 4: port 1 stalls 16 cycles -> abort, drain, then round-robin continues
    clear_mon();
    cfg(1, 1, 4, 1, 16);
    collect(2, 1'b1);
    cfg(0, 1, 1, 0, 0);
    cfg(2, 1, 1, 0, 0);
    collect(43, 1'b1);
    exp_b.push_back(mkb(8'h10, 1'b0, 16'hffff, 1'b0));
    exp_b.push_back(mkb(8'h00, 1'b1, 16'h0001, 1'b1));
    exp_b.push_back(mkb(8'h20, 1'b1, 16'hffff, 1'b0));
    exp_b.push_back(mkb(8'h00, 1'b1, 16'hffff, 1'b0));
    exp_g.push_back(1); exp_g.push_back(2); exp_g.push_back(0);
    check_stream("abort");
    chk("abort underruns", n_under, 16);
    chk("abort pulses", n_abort, 1);
    chk("abort port1 drained", frames_left[1], 0);

    // test 5: 50 cycles of bridge backpressure mid-frame
    clear_mon();
    cfg(3, 1, 3, 0, 0);
    collect(2, 1'b1);
    collect(49, 1'b0);
    pre(1'b0);
    chk("backpressure m_tvalid held", m_tvalid, 1'b1);
    chk("backpressure m_tdata held", m_tdata[7:0], 8'h31);
    chk("backpressure s_tready", s_tready, 4'b0000);
    mon();
    post();
    collect(6, 1'b1);
    for (int i = 0; i < 3; i++) exp_b.push_back(mkb(8'(8'h30 + i), i == 2, 16'hffff, 1'b0));
    exp_g.push_back(3);
    check_stream("backpressure");
    chk("backpressure underruns", n_under, 0);
    chk("backpressure aborts", n_abort, 0);

    // test 6: reset in the middle of a port 3 frame
    clear_mon();
    cfg(3, 1, 4, 0, 0);
    collect(3, 1'b1);
    chk("pre-reset m_tvalid", m_tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid-frame reset m_tvalid", m_tvalid, 1'b0);
    chk("mid-frame reset m_tlast", m_tlast, 1'b0);
    chk("mid-frame reset grant_valid", grant_valid, 1'b0);
    chk("mid-frame reset grant_id", grant_id, 2'd0);
    chk("mid-frame reset s_tready", s_tready, 4'b0000);
    for (int p = 0; p < 4; p++) cfg(p, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    cfg(0, 1, 1, 0, 0);
    cfg(3, 1, 1, 0, 0);
    collect(8, 1'b1);
    exp_b.push_back(mkb(8'h00, 1'b1, 16'hffff, 1'b0));
    exp_b.push_back(mkb(8'h30, 1'b1, 16'hffff, 1'b0));
    exp_g.push_back(0); exp_g.push_back(3);
    check_stream("post-reset");
    chk("post-reset underruns", n_under, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
